// File: rtl/dram_cmd_ingress_queue.sv
// Front-end command ingress for the DRAM controller: per-bank FIFOs fed from the
// host command stream, drained one command per cycle by a round-robin arbiter.
module dram_cmd_ingress_queue #(
    parameter int unsigned NBANK  = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CMD_W  = 36,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              power_on_rst_n,
    input  logic [CMD_W-1:0]  command,
    input  logic              valid,
    input  logic [DATA_W-1:0] write_data,
    output logic [NBANK-1:0]  ba_cmd_pm,
    input  logic [NBANK-1:0]  bank_rdy,
    output logic [CMD_W-1:0]  cmd_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf_err,
    output logic              bad_bank_err,
    output logic [CNT_W-1:0]  nop_cnt,
    output logic [CNT_W-1:0]  acc_cnt
);

    localparam int unsigned BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = CMD_W + DATA_W;

    logic [EW-1:0] mem    [NBANK][DEPTH];
    logic [PW-1:0] wr_ptr [NBANK];
    logic [PW-1:0] rd_ptr [NBANK];
    logic [CW-1:0] count  [NBANK];
    logic [CW-1:0] count_nxt [NBANK];
    logic [BW-1:0] rr_ptr;

    logic [1:0]       rw;
    logic [2:0]       bank_raw;
    logic [BW-1:0]    bank_idx;
    logic             is_acc_c;
    logic             bank_ok_c;
    logic             full_c;
    logic             push_c;
    logic             ovf_c;
    logic [NBANK-1:0] eligible_c;
    logic [NBANK-1:0] push_vec_c;
    logic [NBANK-1:0] pop_vec_c;
    logic [BW-1:0]    grant_c;
    logic             load_c;
    logic [EW-1:0]    head_c;

    assign rw       = command[32:31];
    assign bank_raw = command[2:0];
    assign bank_idx = command[BW-1:0];

    // Ingress decode: full check uses the registered count, so a same-cycle pop cannot rescue a push
    always_comb begin
        is_acc_c  = valid && !rw[1];
        bank_ok_c = 32'(bank_raw) < NBANK;
        full_c    = count[bank_idx] == CW'(DEPTH);
        push_c    = is_acc_c && bank_ok_c && !full_c;
        ovf_c     = is_acc_c && bank_ok_c && full_c;
    end

    // Round-robin grant: first eligible bank at or after rr_ptr
    always_comb begin
        logic found;
        found   = 1'b0;
        grant_c = '0;
        for (int b = 0; b < int'(NBANK); b++) begin
            eligible_c[b] = (count[b] != '0) && bank_rdy[b];
        end
        for (int unsigned i = 0; i < NBANK; i++) begin
            int unsigned idx;
            idx = 32'(rr_ptr) + i;
            if (idx >= NBANK) idx = idx - NBANK;
            if (!found && eligible_c[BW'(idx)]) begin
                grant_c = BW'(idx);
                found   = 1'b1;
            end
        end
        load_c = (!out_valid || out_ready) && (|eligible_c);
        head_c = mem[grant_c][rd_ptr[grant_c]];
    end

    always_comb begin
        for (int b = 0; b < int'(NBANK); b++) begin
            push_vec_c[b] = push_c && (bank_idx == BW'(b));
            pop_vec_c[b]  = load_c && (grant_c == BW'(b));
            count_nxt[b]  = count[b] + CW'(push_vec_c[b]) - CW'(pop_vec_c[b]);
        end
    end

    // Queue storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[bank_idx][wr_ptr[bank_idx]] <= {command, rw[0] ? {DATA_W{1'b0}} : write_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!power_on_rst_n) begin
            for (int b = 0; b < int'(NBANK); b++) begin
                wr_ptr[b] <= '0;
                rd_ptr[b] <= '0;
                count[b]  <= '0;
            end
            ba_cmd_pm <= '1;
        end else begin
            for (int b = 0; b < int'(NBANK); b++) begin
                if (push_vec_c[b]) wr_ptr[b] <= wr_ptr[b] + PW'(1);
                if (pop_vec_c[b])  rd_ptr[b] <= rd_ptr[b] + PW'(1);
                count[b]     <= count_nxt[b];
                ba_cmd_pm[b] <= count_nxt[b] != CW'(DEPTH);
            end
        end
    end

    // Output stage: held while stalled, data keeps last value when it drains
    always_ff @(posedge clk) begin
        if (!power_on_rst_n) begin
            out_valid <= 1'b0;
            cmd_out   <= '0;
            wdata_out <= '0;
            rr_ptr    <= '0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            cmd_out   <= head_c[EW-1:DATA_W];
            wdata_out <= head_c[DATA_W-1:0];
            rr_ptr    <= (32'(grant_c) == NBANK - 1) ? '0 : grant_c + BW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!power_on_rst_n) begin
            ovf_err      <= 1'b0;
            bad_bank_err <= 1'b0;
            nop_cnt      <= '0;
            acc_cnt      <= '0;
        end else begin
            if (ovf_c) ovf_err <= 1'b1;
            if (is_acc_c && !bank_ok_c) bad_bank_err <= 1'b1;
            if (valid && (rw == 2'b10) && (nop_cnt != '1)) nop_cnt <= nop_cnt + CNT_W'(1);
            if (push_c && (acc_cnt != '1)) acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dram_cmd_ingress_queue.sv
// Directed self-checking bench for dram_cmd_ingress_queue.
module tb_dram_cmd_ingress_queue;

    logic         clk = 1'b0;
    logic         power_on_rst_n;
    logic [35:0]  command;
    logic         valid;
    logic [127:0] write_data;
    logic [3:0]   ba_cmd_pm;
    logic [3:0]   bank_rdy;
    logic [35:0]  cmd_out;
    logic [127:0] wdata_out;
    logic         out_valid;
    logic         out_ready;
    logic         ovf_err;
    logic         bad_bank_err;
    logic [15:0]  nop_cnt;
    logic [15:0]  acc_cnt;

    int total = 0;
    int bad   = 0;
    int exp_acc = 0;

    dram_cmd_ingress_queue dut (
        .clk(clk), .power_on_rst_n(power_on_rst_n), .command(command), .valid(valid),
        .write_data(write_data), .ba_cmd_pm(ba_cmd_pm), .bank_rdy(bank_rdy),
        .cmd_out(cmd_out), .wdata_out(wdata_out), .out_valid(out_valid),
        .out_ready(out_ready), .ovf_err(ovf_err), .bad_bank_err(bad_bank_err),
        .nop_cnt(nop_cnt), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] mk_cmd(input logic [1:0] rw, input logic [12:0] row,
                                           input logic [9:0] col, input logic [2:0] bank);
        return {3'd0, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
    endfunction

    // Present one command for exactly one sampling edge; returns at the following negedge.
    task automatic drive_cmd(input logic [35:0] c, input logic [127:0] d);
        valid = 1'b1; command = c; write_data = d;
        @(negedge clk);
        valid = 1'b0; command = '0; write_data = '0;
    endtask

    task automatic apply_reset();
        power_on_rst_n = 1'b0; valid = 1'b0;
        @(negedge clk);
        power_on_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (ba_cmd_pm !== 4'hF) begin bad++; $display("FAIL reset_pm got %h exp f", ba_cmd_pm); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        total++; if (cmd_out !== 36'd0 || wdata_out !== 128'd0) begin bad++; $display("FAIL reset_data got %h/%h exp 0", cmd_out, wdata_out); end
        total++; if ({ovf_err, bad_bank_err} !== 2'b00) begin bad++; $display("FAIL reset_err got %b exp 00", {ovf_err, bad_bank_err}); end
        total++; if (nop_cnt !== 16'd0 || acc_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", nop_cnt, acc_cnt); end
    endtask

    task automatic test_single_write();
        logic [35:0] c;
        c = mk_cmd(2'b00, 13'd5, 10'd8, 3'd0);
        drive_cmd(c, {16{8'hA5}});
        exp_acc++;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_early got %b exp 0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sw_valid got %b exp 1", out_valid); end
        total++; if (cmd_out !== c) begin bad++; $display("FAIL sw_cmd got %h exp %h", cmd_out, c); end
        total++; if (wdata_out !== {16{8'hA5}}) begin bad++; $display("FAIL sw_data got %h exp a5..a5", wdata_out); end
        total++; if (acc_cnt !== 16'(exp_acc)) begin bad++; $display("FAIL sw_acc got %0d exp %0d", acc_cnt, exp_acc); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_pulse got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        bank_rdy = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(mk_cmd(2'b00, 13'd1, 10'(i), 3'd1), 128'(i + 16));
            if (i == 2) begin
                total++; if (ba_cmd_pm[1] !== 1'b1) begin bad++; $display("FAIL ovf_pm3 got %b exp 1", ba_cmd_pm[1]); end
            end
            if (i == 3) begin
                total++; if (ba_cmd_pm[1] !== 1'b0) begin bad++; $display("FAIL ovf_pm4 got %b exp 0", ba_cmd_pm[1]); end
                total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_early got %b exp 0", ovf_err); end
            end
        end
        exp_acc += 4;
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b exp 1", ovf_err); end
        total++; if (acc_cnt !== 16'(exp_acc)) begin bad++; $display("FAIL ovf_acc got %0d exp %0d", acc_cnt, exp_acc); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_idle got %b exp 0", out_valid); end
        bank_rdy = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || cmd_out !== mk_cmd(2'b00, 13'd1, 10'(k), 3'd1) || wdata_out !== 128'(k + 16)) begin
                bad++; $display("FAIL drain_%0d got v=%b cmd=%h d=%h exp col %0d", k, out_valid, cmd_out, wdata_out, k);
            end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_extra got %b exp 0", out_valid); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        exp_acc = 0;
        bank_rdy = 4'h0;
        for (int b = 0; b < 4; b++) drive_cmd(mk_cmd(2'b01, 13'd2, 10'd3, 3'(b)), '1);
        exp_acc += 4;
        bank_rdy = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || cmd_out[2:0] !== 3'(k) || wdata_out !== 128'd0) begin
                bad++; $display("FAIL rr_%0d got v=%b bank=%0d d=%h exp bank %0d d=0", k, out_valid, cmd_out[2:0], wdata_out, k);
            end
        end
        bank_rdy = 4'h0;
        drive_cmd(mk_cmd(2'b01, 13'd4, 10'd4, 3'd2), '0);
        drive_cmd(mk_cmd(2'b01, 13'd4, 10'd4, 3'd0), '0);
        exp_acc += 2;
        bank_rdy = 4'hF;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || cmd_out[2:0] !== 3'd0) begin bad++; $display("FAIL rr_wrap0 got v=%b bank=%0d exp bank 0", out_valid, cmd_out[2:0]); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || cmd_out[2:0] !== 3'd2) begin bad++; $display("FAIL rr_wrap2 got v=%b bank=%0d exp bank 2", out_valid, cmd_out[2:0]); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bank_rdy = 4'hF; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_cmd(mk_cmd(2'b00, 13'd9, 10'(i + 1), 3'd0), 128'(i + 100));
        exp_acc += 5;
        total++; if (out_valid !== 1'b1 || cmd_out !== mk_cmd(2'b00, 13'd9, 10'd1, 3'd0)) begin bad++; $display("FAIL bp_head got v=%b cmd=%h exp col 1", out_valid, cmd_out); end
        total++; if (ba_cmd_pm[0] !== 1'b0) begin bad++; $display("FAIL bp_full got %b exp 0", ba_cmd_pm[0]); end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || cmd_out !== mk_cmd(2'b00, 13'd9, 10'd1, 3'd0) || wdata_out !== 128'd100 || ba_cmd_pm[0] !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d got v=%b cmd=%h pm=%b exp held col 1 pm 0", s, out_valid, cmd_out, ba_cmd_pm[0]);
            end
        end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || cmd_out !== mk_cmd(2'b00, 13'd9, 10'(k + 1), 3'd0) || wdata_out !== 128'(k + 100)) begin
                bad++; $display("FAIL bp_rel_%0d got v=%b cmd=%h d=%h exp col %0d", k, out_valid, cmd_out, wdata_out, k + 1);
            end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end got %b exp 0", out_valid); end
    endtask

    task automatic test_nop_badbank();
        int seen;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(mk_cmd(2'b10, 13'd0, 10'd0, 3'd0), '0);
            if (out_valid !== 1'b0) seen++;
        end
        drive_cmd(mk_cmd(2'b01, 13'd7, 10'd7, 3'd6), '0);
        if (out_valid !== 1'b0) seen++;
        @(negedge clk);
        if (out_valid !== 1'b0) seen++;
        total++; if (seen !== 0) begin bad++; $display("FAIL nb_valid got %0d cycles exp 0", seen); end
        total++; if (nop_cnt !== 16'd3) begin bad++; $display("FAIL nb_nop got %0d exp 3", nop_cnt); end
        total++; if (bad_bank_err !== 1'b1) begin bad++; $display("FAIL nb_bad got %b exp 1", bad_bank_err); end
        total++; if (acc_cnt !== 16'(exp_acc)) begin bad++; $display("FAIL nb_acc got %0d exp %0d", acc_cnt, exp_acc); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL nb_ovf got %b exp 0", ovf_err); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        bank_rdy = 4'h0;
        drive_cmd(mk_cmd(2'b00, 13'd3, 10'd1, 3'd0), 128'd1);
        drive_cmd(mk_cmd(2'b01, 13'd3, 10'd2, 3'd1), 128'd0);
        drive_cmd(mk_cmd(2'b00, 13'd3, 10'd3, 3'd0), 128'd3);
        apply_reset();
        total++; if (ba_cmd_pm !== 4'hF) begin bad++; $display("FAIL rm_pm got %h exp f", ba_cmd_pm); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got %b exp 0", out_valid); end
        total++; if ({nop_cnt, acc_cnt} !== 32'd0) begin bad++; $display("FAIL rm_cnt got %0d/%0d exp 0/0", nop_cnt, acc_cnt); end
        total++; if ({ovf_err, bad_bank_err} !== 2'b00) begin bad++; $display("FAIL rm_err got %b exp 00", {ovf_err, bad_bank_err}); end
        bank_rdy = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rm_stale got %0d cycles exp 0", seen); end
    endtask

    initial begin
        power_on_rst_n = 1'b0; valid = 1'b0; command = '0; write_data = '0;
        bank_rdy = 4'hF; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_nop_badbank();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_cmd_ingress_queue.md
Name: dram_cmd_ingress_queue

Overview:
- Front-end stage of the DRAM controller. Sits directly downstream of the host/pattern command stream.
- Accepts 36-bit access commands plus 128-bit write data on `valid`, sorts them into per-bank FIFOs and reports per-bank acceptance on `ba_cmd_pm`.
- Dispatches one command per cycle to the controller core through a registered valid/ready output stage.
- Bank selection is round-robin among banks the core reports ready.

Parameters:
- NBANK, 4, number of bank queues; the bank index is `command[1:0]`.
- DEPTH, 4, entries per bank FIFO; must be a power of 2.
- CMD_W, 36, command width.
- DATA_W, 128, write-data width (DQ_BITS*8).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- power_on_rst_n  in  1  synchronous active-low reset.
- command  in  CMD_W  {rank[35:33], rw[32:31], 0, row[29:17], 0, bl[15], 0, auto_pre[13], col[12:3], bank[2:0]}; rw 00=write, 01=read, 10=no-op.
- valid  in  1  command/write_data qualifier, sampled each rising edge.
- write_data  in  DATA_W  write payload; meaningful only when rw=00.
- ba_cmd_pm  out  NBANK  bit b=1: bank-b queue can accept a command this cycle.
- bank_rdy  in  NBANK  core bank b can take a command.
- cmd_out  out  CMD_W  dispatched command.
- wdata_out  out  DATA_W  payload paired with cmd_out; 0 for reads.
- out_valid  out  1  cmd_out/wdata_out valid.
- out_ready  in  1  core consumes the output when out_valid&&out_ready.
- ovf_err  out  1  sticky: a push was attempted into a full queue.
- bad_bank_err  out  1  sticky: command arrived with bank[2:0] >= NBANK.
- nop_cnt  out  CNT_W  count of no-op commands dropped.
- acc_cnt  out  CNT_W  count of read/write commands enqueued.

Behaviour:
- Reset (clk edge with power_on_rst_n=0):
  - All FIFO pointers/counts cleared; RR pointer=0.
  - out_valid=0, cmd_out=0, wdata_out=0; ovf_err=0, bad_bank_err=0, nop_cnt=0, acc_cnt=0.
  - Reset mid-operation discards all queued and staged commands, with no output pulse.
- ba_cmd_pm[b] = (count[b] != DEPTH), from registered count only (no ready-through-pop path). After reset all bits are 1.
- Ingress on valid=1, decoded by rw:
  - rw=10: dropped; nop_cnt+1, saturating at all-ones.
  - rw=11: dropped silently.
  - rw=00/01 with bank>=NBANK: dropped; bad_bank_err<=1.
  - rw=00/01, legal bank b, queue not full: {command, write_data or 0} pushed to queue b; acc_cnt+1, saturating.
  - rw=00/01, legal bank b, queue full: dropped; ovf_err<=1. This holds even if queue b pops in the same cycle.
- Eligibility: bank b is eligible when count[b]!=0 and bank_rdy[b]=1.
- Output stage load condition is (!out_valid || out_ready) && any eligible bank.
  - Grant goes to the first eligible bank at or after rr_ptr, wrapping modulo NBANK.
  - The granted head is popped and registered onto cmd_out/wdata_out with out_valid=1.
  - rr_ptr <= grant+1, mod NBANK.
- If out_valid && !out_ready, cmd_out/wdata_out/out_valid are held stable and no pop occurs.
- If out_ready=1 and nothing is eligible, out_valid<=0; data outputs keep their last value.
- Latency: a command sampled at edge N into an empty system, with bank_rdy and out_ready high, shows on cmd_out with out_valid=1 after edge N+1.
- Throughput: one command per cycle sustained.
- Simultaneous push and pop on the same bank: both occur; count is unchanged; FIFO order is preserved.
- Order is preserved per bank only; inter-bank order follows the arbiter.
- Pointer wrap: the DEPTH-power-of-2 index wraps naturally; count is held in a separate register of clog2(DEPTH)+1 bits.

Test Plan:
- Reset, then 1 write (bank0, row 5, col 8, data 128'hA5…A5) with bank_rdy=4'hF, out_ready=1 -> out_valid high exactly 1 cycle after the sampling edge; cmd_out equals the input; wdata_out=A5…A5; acc_cnt=1.
- 5 consecutive writes to bank1 with bank_rdy[1]=0 -> ba_cmd_pm[1] drops to 0 after the 4th; 5th is dropped and ovf_err=1. Then raise bank_rdy[1] -> exactly 4 commands emerge in input order.
- One read each to banks 0..3 queued with bank_rdy=0, then bank_rdy=4'hF -> grants in order 0,1,2,3 on consecutive cycles. Next round with banks 2 and 0 pending -> 0 first (rr_ptr=0 after wrap).
- Hold out_ready=0 for 3 cycles with out_valid=1 -> cmd_out stable, queue counts unchanged. Release -> next command follows the cycle after.
- Stream 3 no-ops then a command with bank=3'd6 -> nop_cnt=3, bad_bank_err=1, out_valid never asserted, acc_cnt unchanged.
- Assert power_on_rst_n=0 for 1 cycle with 3 commands queued -> all ba_cmd_pm=1, out_valid=0, counters and error flags 0, no stale command emitted afterward.
